// File: rtl/shunting_pkg.sv
// Shared definitions for the infix-to-postfix converter: operator codes,
// precedence, token classes and controller states.
package shunting_pkg;

  localparam logic [7:0] OP_ADD = 8'h2B;
  localparam logic [7:0] OP_SUB = 8'h2D;
  localparam logic [7:0] OP_MUL = 8'h2A;
  localparam logic [7:0] OP_DIV = 8'h2F;
  localparam logic [7:0] OP_LP  = 8'h28;
  localparam logic [7:0] OP_RP  = 8'h29;
  localparam logic [7:0] OP_EQ  = 8'h3D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_PAREN,
    S_FLUSH,
    S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    TK_OPERAND,
    TK_BINOP,
    TK_LPAREN,
    TK_RPAREN,
    TK_EQ
  } tok_class_t;

  // Binding strength; 0 for anything that is not a binary operator,
  // which also makes '(' never poppable by an incoming operator.
  function automatic logic [1:0] prec(input logic [7:0] code);
    logic [1:0] p;
    case (code)
      OP_ADD, OP_SUB: p = 2'd1;
      OP_MUL, OP_DIV: p = 2'd2;
      default:        p = 2'd0;
    endcase
    return p;
  endfunction

  // A token only counts as an operator when its upper bits are zero;
  // e.g. 0x12B in a 12-bit stream is an operand.
  function automatic tok_class_t classify(input logic hi_zero, input logic [7:0] lo);
    tok_class_t c;
    c = TK_OPERAND;
    if (hi_zero) begin
      case (lo)
        OP_ADD, OP_SUB, OP_MUL, OP_DIV: c = TK_BINOP;
        OP_LP:   c = TK_LPAREN;
        OP_RP:   c = TK_RPAREN;
        OP_EQ:   c = TK_EQ;
        default: c = TK_OPERAND;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/shunting_yard_conv_op_stack.sv
// Operator LIFO. Only the occupancy is reset; entries above the count are
// don't-care. top is meaningless while empty.
module op_stack #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] top,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  top_ptr;

  assign top_ptr = cnt - CNT_W'(1);
  assign top     = mem[top_ptr[AW-1:0]];
  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;

  // Occupancy: clear beats push beats pop; overflow/underflow are ignored.
  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (push && !full)
      cnt <= cnt + CNT_W'(1);
    else if (pop && !empty)
      cnt <= cnt - CNT_W'(1);
  end

  // Storage write at the current occupancy index.
  always_ff @(posedge clk) begin
    if (push && !full && !clr)
      mem[cnt[AW-1:0]] <= din;
  end

endmodule

// File: rtl/shunting_yard_conv.sv
// Streaming shunting-yard converter: infix tokens in, postfix tokens out,
// one stack action and at most one emitted token per cycle.
module shunting_yard_conv
  import shunting_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              err,
  output logic [CNT_W-1:0]  stk_cnt
);

  state_t            state, state_nxt;
  tok_class_t        tk;
  logic [7:0]        lat_op;

  logic              stk_push, stk_pop, stk_clr;
  logic [DATA_W-1:0] stk_din, stk_top;
  logic              stk_full, stk_empty;

  logic              load, load_last, latch;
  logic [DATA_W-1:0] load_data;

  logic              slot_free, accept;
  logic              top_lp, top_popable, idle_push_ok;

  op_stack #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (stk_push),
    .pop   (stk_pop),
    .clr   (stk_clr),
    .din   (stk_din),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .count (stk_cnt)
  );

  assign tk        = classify((in_data >> 8) == '0, in_data[7:0]);
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = !rst && ((state == S_IDLE && slot_free) || state == S_ERROR);
  assign accept    = in_valid && in_ready;
  assign err       = (state == S_ERROR);

  // Only operators and '(' live on the stack, so the low byte carries prec.
  assign top_lp       = (stk_top == DATA_W'(OP_LP));
  assign top_popable  = !stk_empty && !top_lp && (prec(stk_top[7:0]) >= prec(lat_op));
  assign idle_push_ok = stk_empty || top_lp || (prec(stk_top[7:0]) < prec(in_data[7:0]));

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state decision.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (tk)
            TK_LPAREN: if (stk_full) state_nxt = S_ERROR;
            TK_BINOP: begin
              if (!idle_push_ok)  state_nxt = S_POP;
              else if (stk_full)  state_nxt = S_ERROR;
            end
            TK_RPAREN: state_nxt = S_PAREN;
            TK_EQ:     state_nxt = S_FLUSH;
            default:   state_nxt = S_IDLE;
          endcase
        end
      end
      S_POP: begin
        if (!top_popable)
          state_nxt = stk_full ? S_ERROR : S_IDLE;
      end
      S_PAREN: begin
        if (stk_empty)   state_nxt = S_ERROR;
        else if (top_lp) state_nxt = S_IDLE;
      end
      S_FLUSH: begin
        if (stk_empty) begin
          if (slot_free) state_nxt = S_IDLE;
        end else if (top_lp) begin
          state_nxt = S_ERROR;
        end
      end
      S_ERROR: begin
        if (accept && tk == TK_EQ) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stack and output-register controls for the current state.
  always_comb begin
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_clr   = 1'b0;
    stk_din   = in_data;
    load      = 1'b0;
    load_data = in_data;
    load_last = 1'b0;
    latch     = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (tk)
            TK_OPERAND: load = 1'b1;
            TK_LPAREN:  stk_push = !stk_full;
            TK_BINOP: begin
              if (idle_push_ok) stk_push = !stk_full;
              else              latch = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_POP: begin
        if (top_popable) begin
          if (slot_free) begin
            load      = 1'b1;
            load_data = stk_top;
            stk_pop   = 1'b1;
          end
        end else begin
          stk_push = !stk_full;
          stk_din  = DATA_W'(lat_op);
        end
      end
      S_PAREN: begin
        if (!stk_empty) begin
          if (top_lp) begin
            stk_pop = 1'b1;  // matching '(' is dropped, never emitted
          end else if (slot_free) begin
            load      = 1'b1;
            load_data = stk_top;
            stk_pop   = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (stk_empty) begin
          if (slot_free) begin
            load      = 1'b1;
            load_data = DATA_W'(OP_EQ);
            load_last = 1'b1;
          end
        end else if (!top_lp && slot_free) begin
          load      = 1'b1;
          load_data = stk_top;
          stk_pop   = 1'b1;
        end
      end
      S_ERROR: begin
        if (accept && tk == TK_EQ) stk_clr = 1'b1;
      end
      default: ;
    endcase
  end

  // Single-entry output register; anything pending is dropped on error.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (state_nxt == S_ERROR) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_last  <= load_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Operator held while higher/equal-precedence entries are popped.
  always_ff @(posedge clk) begin
    if (rst)
      lat_op <= '0;
    else if (latch)
      lat_op <= in_data[7:0];
  end

endmodule

// File: doc/shunting_yard_conv.md
Name: shunting_yard_conv

Overview:
Streaming infix-to-postfix converter, successor to the fixed 8-bit postfix block. Shunting-yard algorithm with parametrised token width and operator-stack depth, ready/valid handshakes on both sides, parentheses, four binary operators, and error detection/recovery. Sits between the token source and the stack-based ALU evaluator.

Parameters:
DATA_W, 8, token width (>= 8); operator codes occupy low byte, upper bits zero.
DEPTH, 16, operator stack entries (>= 2).
CNT_W, $clog2(DEPTH+1), stack count width.

Ports:
clk  in  1  clock; all logic rising-edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  input token valid.
in_data  in  DATA_W  infix token.
in_ready  out  1  converter accepts token this cycle.
out_valid  out  1  postfix token valid.
out_data  out  DATA_W  postfix token.
out_last  out  1  marks the '=' terminator token.
out_ready  in  1  downstream accepts.
err  out  1  expression error (high while in ERROR state).
stk_cnt  out  CNT_W  current operator-stack occupancy.

Behaviour:
- Token classes: '+'=0x2B, '-'=0x2D (prec 1); '*'=0x2A, '/'=0x2F (prec 2); '('=0x28, ')'=0x29, '='=0x3D; any other value is an operand.
- Reset: state IDLE, stack empty, out_valid=0, out_data=0, out_last=0, err=0, stk_cnt=0; in_ready=0 while rst high.
- Output register: single entry; slot free = !out_valid || out_ready; out_data/out_last held stable while out_valid && !out_ready.
- States: IDLE, POP, PAREN, FLUSH, ERROR.
- in_ready = !rst && ((IDLE && slot free) || ERROR).
- IDLE, operand accepted: loaded to output register; out_valid next cycle (latency 1).
- IDLE, '(' accepted: pushed same cycle; if stack full -> ERROR.
- IDLE, binary op accepted: if stack empty, top is '(' or prec(top) < prec(op): push same cycle (full -> ERROR). Otherwise latch op, go POP.
- POP, one decision per cycle: if top is a popable operator (prec >= latched op, left-assoc) and slot free: emit top, pop. Else if not popable: push latched op, go IDLE. Slot not free: stall.
- ')' accepted -> PAREN: pop and emit operators one per cycle (slot free); on '(' at top, discard it (not emitted) and go IDLE; stack empty before '(' -> ERROR.
- '=' accepted -> FLUSH: pop and emit all operators one per cycle; '(' encountered -> ERROR. When empty, emit '=' with out_last=1, go IDLE.
- ERROR: err=1, output register cleared (out_valid=0), in_ready=1, all tokens discarded. Accepting '=' clears stack, err=0 next cycle, go IDLE. Nothing emitted for the errored expression.
- No simultaneous push and pop in any cycle; stk_cnt updates the cycle after each push/pop.
- rst mid-expression: stack and output register discarded immediately, no partial output afterwards.
- Operator validity (e.g. two operands in a row) is not checked; tokens pass through in shunting-yard order.

Decomposition:
- Package shunting_pkg: operator code constants, prec() function, state enum, token-class enum.
- Sub-module op_stack: LIFO of DEPTH x DATA_W with push, pop, top, full, empty, count; synchronous reset clears the count only.

Test Plan:
- 3,'+',4,'*',2,'+',1,'=' with out_ready=1 -> out 3,4,2,'*','+',1,'+','='; out_last only on '='; stk_cnt peaks at 2.
- '(',3,'+',4,')','*',2,'=' -> 3,4,'+',2,'*','='; '(' never emitted; err stays 0.
- 8,'-',3,'-',1,'=' -> 8,3,'-',1,'-','=' (left-assoc); 6,'/',2,'*',3,'=' -> 6,2,'/',3,'*','='.
- First expression with out_ready toggling 1/0 every other cycle -> same output sequence; no drops or duplicates; out_data stable while stalled.
- DEPTH=4: five '(' -> err=1 on fifth push; further tokens accepted and dropped; '=' -> err=0, stk_cnt=0; then 1,'+',2,'=' -> 1,2,'+','='.
- 3,')' -> ERROR; '(',3,'=' -> ERROR. rst asserted mid-FLUSH -> out_valid=0, stk_cnt=0 the next cycle.
